// File: rtl/pipe_stage_buf_if.sv
// Beat channel between pipeline stages: valid/ready plus per-lane valid, payload and exception tag.
// master drives the beat, slave drives ready.
interface pipe_stage_buf_if #(
   parameter int LANES  = 2,
   parameter int DATA_W = 128,
   parameter int EXCP_W = 10
);
   logic                    valid;
   logic                    ready;
   logic [LANES-1:0]        lane_valid;
   logic [LANES*DATA_W-1:0] payload;
   logic [LANES-1:0]        excp;
   logic [LANES*EXCP_W-1:0] excp_num;

   modport master (output valid, lane_valid, payload, excp, excp_num, input ready);
   modport slave  (input valid, lane_valid, payload, excp, excp_num, output ready);
endinterface

// File: rtl/pipe_stage_buf.sv
// Multi-lane elastic stage register with 2-entry skid; outputs straight from flops, 1-cycle latency.
// Ready depends only on the skid flop; flush beats everything. PIPE_STAGE_BUF_PERF_EN adds stall_cnt.
module pipe_stage_buf #(
   parameter int LANES  = 2,
   parameter int DATA_W = 128,
   parameter int EXCP_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   pipe_stage_buf_if.slave   up,
   pipe_stage_buf_if.master  dn,
   output logic [1:0]        occupancy
`ifdef PIPE_STAGE_BUF_PERF_EN
   ,
   output logic [31:0]       stall_cnt
`endif
);

   typedef struct packed {
      logic [LANES-1:0]        lv;
      logic [LANES-1:0]        excp;
      logic [LANES*DATA_W-1:0] payload;
      logic [LANES*EXCP_W-1:0] excp_num;
   } beat_t;

   beat_t main_q, skid_q, in_beat;
   logic  main_vld, skid_vld;
   logic  accept, pop;

   // The oldest excepting lane survives; everything younger is squashed at capture.
   always_comb begin
      logic seen;
      seen             = 1'b0;
      in_beat          = '0;
      in_beat.excp     = up.excp;
      in_beat.payload  = up.payload;
      in_beat.excp_num = up.excp_num;
      for (int i = 0; i < LANES; i++) begin
         in_beat.lv[i] = up.lane_valid[i] & ~seen;
         seen          = seen | (up.lane_valid[i] & up.excp[i]);
      end
   end

   assign accept = up.valid & up.ready & (|in_beat.lv);
   assign pop    = main_vld & dn.ready;

   assign up.ready      = ~skid_vld;
   assign dn.valid      = main_vld;
   assign dn.lane_valid = main_q.lv;
   assign dn.excp       = main_q.excp;
   assign dn.payload    = main_q.payload;
   assign dn.excp_num   = main_q.excp_num;
   assign occupancy     = {skid_vld, main_vld & ~skid_vld};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_q   <= '0;
         skid_q   <= '0;
         main_vld <= 1'b0;
         skid_vld <= 1'b0;
      end else if (flush) begin
         main_q   <= '0;
         skid_q   <= '0;
         main_vld <= 1'b0;
         skid_vld <= 1'b0;
      end else if (skid_vld) begin
         if (pop) begin
            main_q   <= skid_q;
            skid_q   <= '0;
            skid_vld <= 1'b0;
         end
      end else if (main_vld) begin
         if (accept && pop) begin
            main_q <= in_beat;
         end else if (accept) begin
            skid_q   <= in_beat;
            skid_vld <= 1'b1;
         end else if (pop) begin
            main_q   <= '0;
            main_vld <= 1'b0;
         end
      end else if (accept) begin
         main_q   <= in_beat;
         main_vld <= 1'b1;
      end
   end

`ifdef PIPE_STAGE_BUF_PERF_EN
   // Survives flush on purpose so stalls across a redirect are still counted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (main_vld && !dn.ready && (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed scenarios plus randomized traffic against a queue-based reference of the stage buffer.
module tb_pipe_stage_buf;
   localparam int LANES  = 2;
   localparam int DATA_W = 128;
   localparam int EXCP_W = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       flush = 1'b0;
   logic [1:0] occupancy;
`ifdef PIPE_STAGE_BUF_PERF_EN
   logic [31:0] stall_cnt;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   pipe_stage_buf_if #(.LANES(LANES), .DATA_W(DATA_W), .EXCP_W(EXCP_W)) up ();
   pipe_stage_buf_if #(.LANES(LANES), .DATA_W(DATA_W), .EXCP_W(EXCP_W)) dn ();

   pipe_stage_buf #(.LANES(LANES), .DATA_W(DATA_W), .EXCP_W(EXCP_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .up        (up),
      .dn        (dn),
      .occupancy (occupancy)
`ifdef PIPE_STAGE_BUF_PERF_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   typedef struct packed {
      logic [LANES-1:0]        lv;
      logic [LANES-1:0]        excp;
      logic [LANES*DATA_W-1:0] payload;
      logic [LANES*EXCP_W-1:0] excp_num;
   } beat_t;

   beat_t q[$];

   function automatic beat_t mk(input logic [1:0] lv, input logic [1:0] ex,
                                input logic [127:0] p0, input logic [127:0] p1,
                                input logic [9:0] n0, input logic [9:0] n1);
      beat_t b;
      b.lv = lv; b.excp = ex; b.payload = {p1, p0}; b.excp_num = {n1, n0};
      return b;
   endfunction

   // Keep lanes up to and including the first excepting valid lane.
   function automatic logic [LANES-1:0] squash(input logic [LANES-1:0] lv, input logic [LANES-1:0] ex);
      int k = LANES;
      for (int i = LANES - 1; i >= 0; i--) if (lv[i] && ex[i]) k = i;
      if (k == LANES) return lv;
      return lv & LANES'((1 << (k + 1)) - 1);
   endfunction

   task automatic drive(input logic v, input beat_t b);
      up.valid = v; up.lane_valid = b.lv; up.excp = b.excp;
      up.payload = b.payload; up.excp_num = b.excp_num;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #2;
      tests++; if (dn.valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %0b exp 0", dn.valid); end
      tests++; if (up.ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got %0b exp 1", up.ready); end
      tests++; if (occupancy !== 2'd0) begin fails++; $display("FAIL rst_occ got %0d exp 0", occupancy); end
      tests++; if ({dn.lane_valid, dn.excp, dn.payload, dn.excp_num} !== '0) begin fails++; $display("FAIL rst_outputs not zero"); end
      @(negedge clk); rst = 1'b1;
   endtask

   task automatic test_single_beat();
      dn.ready = 1'b1;
      drive(1'b1, mk(2'b11, 2'b00, 128'h11, 128'h22, 10'h0, 10'h0));
      step();
      drive(1'b0, '0);
      tests++; if (dn.valid !== 1'b1) begin fails++; $display("FAIL single_valid got %0b exp 1", dn.valid); end
      tests++; if (dn.payload !== {128'h22, 128'h11}) begin fails++; $display("FAIL single_payload got %h", dn.payload); end
      tests++; if (dn.lane_valid !== 2'b11) begin fails++; $display("FAIL single_lv got %b exp 11", dn.lane_valid); end
      step();
      tests++; if (dn.valid !== 1'b0) begin fails++; $display("FAIL single_drain_valid got %0b exp 0", dn.valid); end
      tests++; if (occupancy !== 2'd0) begin fails++; $display("FAIL single_drain_occ got %0d exp 0", occupancy); end
   endtask

   task automatic test_backpressure();
      beat_t a, b, c;
      a = mk(2'b11, 2'b00, 128'hA0, 128'hA1, 10'h1, 10'h2);
      b = mk(2'b01, 2'b00, 128'hB0, 128'hB1, 10'h3, 10'h4);
      c = mk(2'b10, 2'b00, 128'hC0, 128'hC1, 10'h5, 10'h6);
      dn.ready = 1'b0;
      drive(1'b1, a); step();
      drive(1'b1, b); step();
      drive(1'b1, c);
      tests++; if (up.ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready got %0b exp 0", up.ready); end
      tests++; if (occupancy !== 2'd2) begin fails++; $display("FAIL bp_occ got %0d exp 2", occupancy); end
      step();
      tests++; if (dn.payload !== a.payload) begin fails++; $display("FAIL bp_hold_A got %h", dn.payload); end
      dn.ready = 1'b1;
      step();
      tests++; if (dn.payload !== b.payload || dn.lane_valid !== b.lv) begin fails++; $display("FAIL bp_seq_B got %h lv %b", dn.payload, dn.lane_valid); end
      step();
      drive(1'b0, '0);
      tests++; if (dn.payload !== c.payload || dn.lane_valid !== c.lv) begin fails++; $display("FAIL bp_seq_C got %h lv %b", dn.payload, dn.lane_valid); end
      step();
      tests++; if (dn.valid !== 1'b0) begin fails++; $display("FAIL bp_no_dup valid got %0b exp 0", dn.valid); end
   endtask

   task automatic test_squash();
      dn.ready = 1'b1;
      drive(1'b1, mk(2'b11, 2'b01, 128'h5, 128'h6, 10'h0C0, 10'h3FF));
      step();
      drive(1'b0, '0);
      tests++; if (dn.lane_valid !== 2'b01) begin fails++; $display("FAIL squash_lv got %b exp 01", dn.lane_valid); end
      tests++; if (dn.excp !== 2'b01) begin fails++; $display("FAIL squash_excp got %b exp 01", dn.excp); end
      tests++; if (dn.excp_num[9:0] !== 10'h0C0) begin fails++; $display("FAIL squash_num0 got %h exp 0c0", dn.excp_num[9:0]); end
      step();
   endtask

   task automatic test_empty_beat();
      drive(1'b1, mk(2'b00, 2'b00, 128'h9, 128'h9, 10'h0, 10'h0));
      #1;
      tests++; if (up.ready !== 1'b1) begin fails++; $display("FAIL empty_in_ready got %0b exp 1", up.ready); end
      step();
      drive(1'b0, '0);
      tests++; if (dn.valid !== 1'b0) begin fails++; $display("FAIL empty_valid got %0b exp 0", dn.valid); end
      tests++; if (occupancy !== 2'd0) begin fails++; $display("FAIL empty_occ got %0d exp 0", occupancy); end
   endtask

   task automatic test_flush();
      dn.ready = 1'b0;
      drive(1'b1, mk(2'b11, 2'b10, 128'h1, 128'h2, 10'h7, 10'h8)); step();
      drive(1'b1, mk(2'b01, 2'b00, 128'h3, 128'h4, 10'h9, 10'hA)); step();
      tests++; if (occupancy !== 2'd2) begin fails++; $display("FAIL flush_pre_occ got %0d exp 2", occupancy); end
      drive(1'b1, mk(2'b11, 2'b00, 128'hF0, 128'hF1, 10'h0, 10'h0));
      flush = 1'b1;
      step();
      flush = 1'b0;
      drive(1'b0, '0);
      tests++; if (dn.valid !== 1'b0) begin fails++; $display("FAIL flush_valid got %0b exp 0", dn.valid); end
      tests++; if (occupancy !== 2'd0) begin fails++; $display("FAIL flush_occ got %0d exp 0", occupancy); end
      tests++; if (up.ready !== 1'b1) begin fails++; $display("FAIL flush_in_ready got %0b exp 1", up.ready); end
      tests++; if ({dn.lane_valid, dn.excp, dn.payload, dn.excp_num} !== '0) begin fails++; $display("FAIL flush_outputs not zero"); end
      step();
      tests++; if (dn.valid !== 1'b0) begin fails++; $display("FAIL flush_dropped_beat valid got %0b exp 0", dn.valid); end
   endtask

   task automatic test_async_reset();
      #2 rst = 1'b0;
      #1 rst = 1'b1;
      dn.ready = 1'b0;
      drive(1'b1, mk(2'b01, 2'b00, 128'hD0, 128'h0, 10'h1, 10'h0)); step();
      drive(1'b1, mk(2'b11, 2'b00, 128'hE0, 128'hE1, 10'h2, 10'h3)); step();
      drive(1'b0, '0);
      for (int i = 0; i < 4; i++) step();
      tests++; if (occupancy !== 2'd2) begin fails++; $display("FAIL arst_pre_occ got %0d exp 2", occupancy); end
`ifdef PIPE_STAGE_BUF_PERF_EN
      tests++; if (stall_cnt !== 32'd5) begin fails++; $display("FAIL stall_cnt got %0d exp 5", stall_cnt); end
`endif
      #3 rst = 1'b0;
      #1;
      tests++; if (dn.valid !== 1'b0) begin fails++; $display("FAIL arst_valid got %0b exp 0", dn.valid); end
      tests++; if (occupancy !== 2'd0) begin fails++; $display("FAIL arst_occ got %0d exp 0", occupancy); end
      tests++; if (up.ready !== 1'b1) begin fails++; $display("FAIL arst_in_ready got %0b exp 1", up.ready); end
      tests++; if ({dn.lane_valid, dn.excp, dn.payload, dn.excp_num} !== '0) begin fails++; $display("FAIL arst_outputs not zero"); end
`ifdef PIPE_STAGE_BUF_PERF_EN
      tests++; if (stall_cnt !== 32'd0) begin fails++; $display("FAIL arst_stall_cnt got %0d exp 0", stall_cnt); end
`endif
      #2 rst = 1'b1;
   endtask

   task automatic test_random();
      beat_t b;
      logic  v, rdy, fl, acc, pp;
      q.delete();
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         tests++; if (dn.valid !== (q.size() > 0)) begin fails++; $display("FAIL rnd_valid cyc %0d got %0b exp %0b", c, dn.valid, q.size() > 0); end
         tests++; if (occupancy !== 2'(q.size())) begin fails++; $display("FAIL rnd_occ cyc %0d got %0d exp %0d", c, occupancy, q.size()); end
         tests++; if (up.ready !== (q.size() < 2)) begin fails++; $display("FAIL rnd_in_ready cyc %0d got %0b exp %0b", c, up.ready, q.size() < 2); end
         if (q.size() > 0) begin
            tests++;
            if ({dn.lane_valid, dn.excp, dn.payload, dn.excp_num} !== q[0]) begin
               fails++; $display("FAIL rnd_beat cyc %0d got lv %b payload %h exp lv %b payload %h", c, dn.lane_valid, dn.payload, q[0].lv, q[0].payload);
            end
         end
         b.lv = LANES'($urandom); b.excp = ($urandom_range(0, 3) == 0) ? LANES'($urandom) : '0;
         for (int w = 0; w < LANES * DATA_W / 32; w++) b.payload[32*w +: 32] = $urandom;
         b.excp_num = (LANES*EXCP_W)'($urandom);
         v   = ($urandom_range(0, 3) != 0);
         rdy = ($urandom_range(0, 2) != 0);
         fl  = ($urandom_range(0, 31) == 0);
         drive(v, b); dn.ready = rdy; flush = fl;
         acc = v && (q.size() < 2) && (squash(b.lv, b.excp) != '0);
         pp  = (q.size() > 0) && rdy;
         if (fl) q.delete();
         else begin
            if (pp) void'(q.pop_front());
            if (acc) begin b.lv = squash(b.lv, b.excp); q.push_back(b); end
         end
      end
      @(negedge clk);
      drive(1'b0, '0); flush = 1'b0;
   endtask

   initial begin
      drive(1'b0, '0);
      dn.ready = 1'b0;
      test_reset();
      test_single_beat();
      test_backpressure();
      test_squash();
      test_empty_beat();
      test_flush();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised, multi-lane elastic pipeline register for stage boundaries (EX->MEM first user; also ID->EX, MEM->WB).
- Carries LANES instruction slots per beat, each with an opaque payload and an exception tag.
- Has a valid/ready handshake with a 2-entry skid, so back-pressure never drops or duplicates a beat.
- Flush has priority over everything; exceptions squash younger lanes at capture.

Parameters:
LANES, 2, instruction slots per beat (1..4); lane 0 is oldest
DATA_W, 128, payload bits per lane
EXCP_W, 10, exception-number bits per lane

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
flush  in  1  synchronous pipeline flush (branch/excp/ertn OR'd upstream)
in_valid  in  1  upstream beat valid
in_ready  out  1  beat accepted when in_valid && in_ready
in_lane_valid  in  LANES  per-lane instruction valid
in_payload  in  LANES*DATA_W  lane i at [i*DATA_W +: DATA_W]
in_excp  in  LANES  per-lane exception flag
in_excp_num  in  LANES*EXCP_W  per-lane exception code
out_valid  out  1  downstream beat valid
out_ready  in  1  downstream accepts when out_valid && out_ready
out_lane_valid  out  LANES  per-lane valid after squash
out_payload  out  LANES*DATA_W  registered payload
out_excp  out  LANES  registered exception flags
out_excp_num  out  LANES*EXCP_W  registered exception codes
occupancy  out  2  entries held, 0..2

Behaviour:
- Storage: main entry drives the outputs directly; skid entry holds the overflow beat. All outputs come straight from flops; no combinational in->out path.
- Reset (rst=0, asynchronous): both entries invalid. out_valid=0, in_ready=1, occupancy=0. All lane_valid, excp, payload and excp_num are 0.
- in_ready = !skid_valid. It is registered and does not depend on out_ready in the same cycle.
- Accept rule: accept = in_valid && in_ready. Pop rule: pop = out_valid && out_ready.
- Capture squash: let k be the lowest lane with in_lane_valid[k] && in_excp[k]. Stored lane_valid for lanes > k is 0; lane k and lower keep their input values.
- Empty beat: an accepted beat whose squashed lane_valid is all-zero is consumed and discarded. It occupies no entry.
- Transitions, by occupancy, with accept A and pop P (empty beats count as not A):
  - 0: A -> main, occ=1.
  - 1: A&P -> main<=in, occ=1. A&!P -> skid<=in, occ=2. !A&P -> occ=0. Otherwise hold.
  - 2 (in_ready=0): P -> main<=skid, occ=1. !P -> hold.
- Latency: 1 cycle from accept to out_valid when empty. Throughput is 1 beat/cycle with out_ready held high.
- Beat order is strictly preserved. A held entry is bit-stable while out_valid && !out_ready.
- flush=1: both entries invalidated and zeroed next edge; occupancy=0, in_ready=1. A beat presented in the same cycle is dropped; a pop in the same cycle still counts for downstream.
- Reset during operation: immediate clear regardless of clk, flush or handshake state.

Optional Feature:
- PIPE_STAGE_BUF_PERF_EN defined:
  - Adds output stall_cnt [31:0], counting cycles with out_valid && !out_ready.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by rst only; not cleared by flush.
- Not defined: the port and counter do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset then single beat: LANES=2, lane_valid=2'b11, payload0=0x11, payload1=0x22, out_ready=1 -> next cycle out_valid=1 with payloads 0x11/0x22; following cycle out_valid=0, occupancy=0.
- Back-pressure: out_ready=0, three consecutive beats A,B,C -> A in main, B in skid, in_ready=0 during C (C held upstream). Raise out_ready -> output sequence A,B,C on consecutive cycles, none lost or duplicated.
- Exception squash: lane_valid=2'b11, in_excp=2'b01, excp_num0=10'h0C0 -> out_lane_valid=2'b01, out_excp=2'b01, out_excp_num0=10'h0C0.
- Empty beat: in_valid=1, lane_valid=2'b00 -> accepted (in_ready=1), out_valid stays 0, occupancy stays 0.
- Flush at occupancy=2 with in_valid=1 -> next cycle out_valid=0, occupancy=0, in_ready=1, all outputs 0; the incoming beat is not seen.
- Async reset mid-stall: assert rst=0 between clock edges at occupancy=2 -> outputs clear immediately. With PIPE_STAGE_BUF_PERF_EN, stall_cnt = 5 after 5 stalled cycles, then returns to 0 on rst.
